// File: rtl/alu_pkg.sv
// Shared types for the 7-bit ALU: opcode encoding, status flag bundle and default width.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 7;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_SHL = 3'd4,
      OP_SHR = 3'd5,
      OP_XOR = 3'd6,
      OP_NOT = 3'd7
   } op_e;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
      logic negative;
   } flags_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational logical shifter with shift-out bit; any shift amount >= WIDTH
// yields zero result and zero shift-out.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] n,
   input  logic             dir,   // 0 = left, 1 = right
   output logic [WIDTH-1:0] y,
   output logic             c
);

   localparam logic [WIDTH-1:0] N_LIMIT = WIDTH'(WIDTH);

   logic [WIDTH:0] wide;

   // One extra bit on the exit side captures the last bit shifted out.
   always_comb begin
      wide = '0;
      if (n < N_LIMIT) begin
         if (dir) wide = {a, 1'b0} >> n;
         else     wide = {1'b0, a} << n;
      end
      y = dir ? wide[WIDTH:1] : wide[WIDTH-1:0];
      c = dir ? wide[0]       : wide[WIDTH];
   end

endmodule

// File: rtl/alu7_core.sv
// Registered ALU: operands sampled on in_valid, result and flags available one
// cycle later with a single-cycle out_valid pulse.
module alu7_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op_sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam flags_t FLAGS_RST = '{carry: 1'b0, overflow: 1'b0, zero: 1'b1, negative: 1'b0};

   op_e              op;
   logic             sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sh_y;
   logic             sh_c;
   logic [WIDTH-1:0] result_d, result_q;
   flags_t           flags_d, flags_q;
   logic             valid_q;

   alu_shifter #(.WIDTH(WIDTH)) u_shifter (
      .a   (a),
      .n   (b),
      .dir (op == OP_SHR),
      .y   (sh_y),
      .c   (sh_c)
   );

   // Subtract reuses the adder as a + ~b + 1, so one overflow rule covers both.
   always_comb begin
      op    = op_e'(op_sel);
      sub   = (op == OP_SUB);
      b_eff = sub ? ~b : b;
      sum   = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(sub);

      result_d         = sum[WIDTH-1:0];
      flags_d          = '0;
      flags_d.carry    = sum[WIDTH];
      flags_d.overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

      unique case (op)
         OP_ADD, OP_SUB: ;
         OP_AND: begin result_d = a & b; flags_d.carry = 1'b0; flags_d.overflow = 1'b0; end
         OP_OR:  begin result_d = a | b; flags_d.carry = 1'b0; flags_d.overflow = 1'b0; end
         OP_XOR: begin result_d = a ^ b; flags_d.carry = 1'b0; flags_d.overflow = 1'b0; end
         OP_NOT: begin result_d = ~a;    flags_d.carry = 1'b0; flags_d.overflow = 1'b0; end
         OP_SHL, OP_SHR: begin
            result_d         = sh_y;
            flags_d.carry    = sh_c;
            flags_d.overflow = 1'b0;
         end
         default: ;
      endcase

      flags_d.zero     = (result_d == '0);
      flags_d.negative = result_d[WIDTH-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         flags_q  <= FLAGS_RST;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            result_q <= result_d;
            flags_q  <= flags_d;
         end
      end
   end

   assign out_valid = valid_q;
   assign result    = result_q;
   assign carry_out = flags_q.carry;
   assign overflow  = flags_q.overflow;
   assign zero      = flags_q.zero;
   assign negative  = flags_q.negative;

endmodule

// File: tb/tb_alu7_core.sv
// Scoreboard bench for alu7_core: a reference model pushes expected results when
// an operation is issued; they are popped and compared one cycle later.
module tb_alu7_core;

   typedef struct packed {
      logic       v;
      logic [6:0] r;
      logic       c;
      logic       o;
      logic       z;
      logic       n;
   } res_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [6:0] a, b;
   logic [2:0] op_sel;
   logic       out_valid;
   logic [6:0] result;
   logic       carry_out, overflow, zero, negative;

   int   total = 0;
   int   bad   = 0;
   res_t sb[$];

   localparam res_t RST_VAL = '{v: 1'b0, r: 7'd0, c: 1'b0, o: 1'b0, z: 1'b1, n: 1'b0};

   alu7_core #(.WIDTH(7)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .op_sel    (op_sel),
      .out_valid (out_valid),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero),
      .negative  (negative)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int sgn(input int x);
      return (x >= 64) ? x - 128 : x;
   endfunction

   function automatic res_t model(input int op, input int av, input int bv);
      res_t e;
      int   s;
      e   = '0;
      e.v = 1'b1;
      case (op)
         0: begin
            s   = av + bv;
            e.r = 7'(s % 128);
            e.c = (s >= 128);
            s   = sgn(av) + sgn(bv);
            e.o = (s > 63) || (s < -64);
         end
         1: begin
            e.r = 7'((av - bv + 128) % 128);
            e.c = (av >= bv);
            s   = sgn(av) - sgn(bv);
            e.o = (s > 63) || (s < -64);
         end
         2: e.r = 7'(av & bv);
         3: e.r = 7'(av | bv);
         4: begin
            if (bv == 0) e.r = 7'(av);
            else if (bv < 7) begin
               e.r = 7'((av * (1 << bv)) % 128);
               e.c = ((av >> (7 - bv)) & 1) != 0;
            end
         end
         5: begin
            if (bv == 0) e.r = 7'(av);
            else if (bv < 7) begin
               e.r = 7'(av >> bv);
               e.c = ((av >> (bv - 1)) & 1) != 0;
            end
         end
         6: e.r = 7'(av ^ bv);
         default: e.r = 7'(127 - av);
      endcase
      e.z = (e.r == 7'd0);
      e.n = e.r[6];
      return e;
   endfunction

   function automatic res_t observe();
      return '{v: out_valid, r: result, c: carry_out, o: overflow, z: zero, n: negative};
   endfunction

   task automatic send(input int op, input int av, input int bv);
      @(negedge clk);
      in_valid = 1'b1;
      op_sel   = 3'(op);
      a        = 7'(av);
      b        = 7'(bv);
      sb.push_back(model(op, av, bv));
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      res_t exp, obs;
      #1;
      obs = observe();
      total++;
      if (obs !== RST_VAL) begin bad++; $display("FAIL reset_init got=%h exp=%h", obs, RST_VAL); end
      @(negedge clk);
      rst = 1'b0;
      send(0, 10, 5);
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = observe();
      total++;
      if (obs !== exp || obs.r !== 7'd15) begin bad++; $display("FAIL reset_add got=%h exp=%h", obs, exp); end
      send(0, 100, 100);
      @(posedge clk); #3;
      void'(sb.pop_front());
      rst = 1'b1;
      sb.delete();
      #1;
      obs = observe();
      total++;
      if (obs !== RST_VAL) begin bad++; $display("FAIL reset_async got=%h exp=%h", obs, RST_VAL); end
      @(posedge clk); #1;
      obs = observe();
      total++;
      if (obs !== RST_VAL) begin bad++; $display("FAIL reset_discard got=%h exp=%h", obs, RST_VAL); end
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      @(posedge clk); #1;
      obs = observe();
      total++;
      if (obs !== RST_VAL) begin bad++; $display("FAIL reset_release got=%h exp=%h", obs, RST_VAL); end
   endtask

   task automatic test_arith();
      int   ops[6] = '{0, 1, 1, 0, 1, 0};
      int   av[6]  = '{10, 10, 5, 63, 64, 127};
      int   bv[6]  = '{5, 5, 10, 1, 1, 1};
      res_t exp, obs;
      for (int i = 0; i < 6; i++) begin
         send(ops[i], av[i], bv[i]);
         @(posedge clk); #1;
         exp = sb.pop_front();
         obs = observe();
         total++;
         if (obs !== exp) begin bad++; $display("FAIL arith_%0d got=%h exp=%h", i, obs, exp); end
      end
   endtask

   task automatic test_logic();
      res_t exp, obs;
      for (int op = 2; op < 8; op++) begin
         if (op == 4 || op == 5) continue;
         send(op, 7'b1010101, 7'b0101010);
         @(posedge clk); #1;
         exp = sb.pop_front();
         obs = observe();
         total++;
         if (obs !== exp) begin bad++; $display("FAIL logic_op%0d got=%h exp=%h", op, obs, exp); end
      end
   endtask

   task automatic test_shift();
      int   ops[9] = '{4, 5, 4, 5, 4, 5, 4, 5, 5};
      int   bv[9]  = '{4, 1, 7, 8, 0, 0, 6, 6, 127};
      res_t exp, obs;
      for (int i = 0; i < 9; i++) begin
         send(ops[i], 7'b1010101, bv[i]);
         @(posedge clk); #1;
         exp = sb.pop_front();
         obs = observe();
         total++;
         if (obs !== exp) begin bad++; $display("FAIL shift_%0d got=%h exp=%h", i, obs, exp); end
      end
   endtask

   task automatic test_hold();
      res_t last, obs;
      idle();
      @(posedge clk); #1;
      last   = observe();
      last.v = 1'b1;
      send(1, 5, 10);
      @(posedge clk); #1;
      last = sb.pop_front();
      idle();
      last.v = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         obs = observe();
         total++;
         if (obs !== last) begin bad++; $display("FAIL hold_%0d got=%h exp=%h", i, obs, last); end
      end
   endtask

   task automatic test_back_to_back();
      res_t exp, obs;
      int   opv, avv, bvv;
      for (int i = 0; i < 24; i++) begin
         opv = (i < 4) ? i * 2 + 1 : int'($urandom_range(0, 7));
         avv = int'($urandom_range(0, 127));
         bvv = (i % 5 == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 127));
         send(opv, avv, bvv);
         @(posedge clk); #1;
         total++;
         if (sb.size() == 0) begin bad++; $display("FAIL b2b_empty_%0d got=nothing exp=entry", i); end
         else begin
            exp = sb.pop_front();
            obs = observe();
            if (obs !== exp) begin
               bad++;
               $display("FAIL b2b_%0d op=%0d a=%0d b=%0d got=%h exp=%h", i, opv, avv, bvv, obs, exp);
            end
         end
      end
      idle();
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", out_valid); end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      op_sel   = '0;
      test_reset();
      test_arith();
      test_logic();
      test_shift();
      test_hold();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu7_core.md
Name: alu7_core

Overview:
- Registered 7-bit integer ALU with four status flags: add, subtract, AND, OR, logical shift left/right, XOR, NOT.
- Operands and opcode are sampled on a qualified clock edge; result and flags come out registered one cycle later.
- Serves as the arithmetic execution block of the small datapath and feeds flags to downstream condition logic.

Parameters:
- WIDTH, 7, operand/result width in bits; all rules below are written for WIDTH and tested at 7.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands/opcode valid this cycle; sampled at the rising edge of clk
- a  input  WIDTH  operand A (unsigned, or two's complement for V/N)
- b  input  WIDTH  operand B; shift amount for shift ops
- op_sel  input  3  operation select
- out_valid  output  1  result/flags updated by the previous accepted operation (one-cycle pulse)
- result  output  WIDTH  registered result
- carry_out  output  1  registered carry/borrow/shift-out flag
- overflow  output  1  registered signed overflow flag
- zero  output  1  registered, 1 when result is all zeros
- negative  output  1  registered, equal to result MSB

Behaviour:
- Reset: rst=1 asynchronously clears result, carry_out, overflow and out_valid to 0, and sets zero=1, negative=0. Reset asserted mid-operation discards the pending operation.
- Latency: one cycle. If in_valid=1 at edge k, then at edge k the registers load the outputs of that operation and out_valid=1 until edge k+1.
- If in_valid=0 at an edge, out_valid=0 and result/flags hold their previous values.
- No backpressure: every valid input is accepted, so back-to-back operations give back-to-back results.
- Opcodes:
  - 000 ADD: {c, r} = a + b
  - 001 SUB: computed as a + ~b + 1; c = carry out, so 1 means no borrow (a >= b unsigned)
  - 010 AND: r = a & b
  - 011 OR: r = a | b
  - 100 SHL: logical left shift of a by n = b (unsigned)
  - 101 SHR: logical right shift of a by n = b (unsigned)
  - 110 XOR: r = a ^ b
  - 111 NOT: r = ~a (b ignored)
- Shift rules:
  - n = 0: r = a, c = 0.
  - 1 <= n <= WIDTH-1: SHL gives c = a[WIDTH-n]; SHR gives c = a[n-1].
  - n >= WIDTH: r = 0, c = 0. The full b value is used; it is not truncated to low bits.
- carry_out is 0 for the logic ops (AND, OR, XOR, NOT).
- overflow: for ADD, 1 when a and b have the same sign and r has a different sign. For SUB, 1 when a and b have different signs and the sign of r differs from a. 0 for all other ops.
- zero = (r == 0); negative = r[WIDTH-1]; both are computed from the same-cycle r and registered with it.
- All arithmetic wraps modulo 2^WIDTH.

Decomposition:
- Package alu_pkg:
  - op_e enum: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_SHL=4, OP_SHR=5, OP_XOR=6, OP_NOT=7
  - flag struct {carry, overflow, zero, negative}
  - default WIDTH constant
- Sub-module alu_shifter (combinational): inputs a, n, dir; outputs shifted value and shift-out bit, including the n >= WIDTH saturation rule.
- Top level holds the adder/subtractor, logic ops, result mux, flag generation and output registers.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> result=0, zero=1, carry_out=0, overflow=0, negative=0, out_valid=0 immediately. Issue ADD 10+5 one cycle -> next edge result=15, all flags 0, out_valid=1 for one cycle.
- SUB 10-5 -> result=5, carry_out=1. SUB 5-10 -> result=0x7B, carry_out=0, negative=1. ADD 63+1 -> result=64, overflow=1, negative=1. SUB 64-1 -> result=63, overflow=1.
- Logic ops on a=1010101b, b=0101010b:
  - AND -> 0, zero=1
  - OR -> 1111111b, negative=1
  - XOR -> 1111111b
  - NOT a -> 0101010b
- Shifts with a=1010101b:
  - SHL b=4 -> 1010000b, carry_out=0, negative=1
  - SHR b=1 -> 0101010b, carry_out=1
  - SHL b=7 and SHR b=8 -> result 0, zero=1, carry_out=0
  - shift by b=0 -> result=a, carry_out=0
- Hold/streaming: in_valid low for 3 cycles -> outputs hold and out_valid=0. Then 4 back-to-back valid ops -> 4 consecutive results, each one cycle after its input.
